// File: rtl/mlaccel_acc_bank.sv
// NCH-channel accumulator bank with signed max reduction, masked updates and a
// back-pressured 8-bit write port. Define MLACCEL_ACC_ROUND_EN for round-half-up stores.
module mlaccel_acc_bank #(
    parameter int NCH  = 2,
    parameter int SZ   = 8,
    parameter int ACCW = 32,
    parameter int AW   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [3:0]             op_code,
    input  logic [NCH-1:0]         op_mask,
    input  logic [NCH*SZ*16-1:0]   op_prod,
    input  logic [NCH*ACCW-1:0]    op_ldata,
    input  logic [4:0]             op_shift,
    input  logic [AW-1:0]          op_addr,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [NCH-1:0]         wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [8*NCH-1:0]       wr_data,
    output logic                   busy
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MACC  = 4'd1,
        OP_MACCZ = 4'd2,
        OP_MMAX  = 4'd3,
        OP_MMAXZ = 4'd4,
        OP_MMAXN = 4'd5,
        OP_LDSET = 4'd6,
        OP_LDADD = 4'd7,
        OP_LDMAX = 4'd8,
        OP_STORE = 4'd9,
        OP_RELU  = 4'd10
    } op_e;

    localparam logic signed [ACCW:0] SAT_HI = (ACCW+1)'(127);
    localparam logic signed [ACCW:0] SAT_LO = (ACCW+1)'(-128);

    op_e                    opCode;
    logic                   fire;
    logic                   isStore;
    logic [4:0]             shAmt;

    logic signed [ACCW-1:0] acc_q   [NCH];
    logic signed [ACCW-1:0] acc_d   [NCH];
    logic signed [ACCW-1:0] laneSum [NCH];
    logic signed [ACCW-1:0] laneMax [NCH];
    logic signed [ACCW-1:0] ldWord  [NCH];
    logic signed [ACCW:0]   wide    [NCH];
    logic signed [ACCW:0]   shifted [NCH];
    logic [7:0]             resByte [NCH];

    logic                   wr_valid_q, wr_valid_d;
    logic [NCH-1:0]         wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [8*NCH-1:0]       wr_data_q, wr_data_d;

    function automatic logic signed [ACCW-1:0] sext16(input logic [15:0] v);
        return {{(ACCW-16){v[15]}}, v};
    endfunction

    function automatic logic signed [ACCW-1:0] smax(input logic signed [ACCW-1:0] a,
                                                     input logic signed [ACCW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign opCode   = op_e'(op_code);
    assign op_ready = !wr_valid_q || wr_ready;
    assign fire     = op_valid && op_ready;
    assign isStore  = (opCode == OP_STORE) || (opCode == OP_RELU);
    assign shAmt    = (32'(op_shift) >= 32'(ACCW)) ? 5'(ACCW-1) : op_shift;

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            laneSum[c] = '0;
            laneMax[c] = sext16(op_prod[16*c*SZ +: 16]);
            for (int i = 0; i < SZ; i++) begin
                laneSum[c] = laneSum[c] + sext16(op_prod[16*(c*SZ+i) +: 16]);
                laneMax[c] = smax(laneMax[c], sext16(op_prod[16*(c*SZ+i) +: 16]));
            end
            ldWord[c] = op_ldata[ACCW*c +: ACCW];
        end
    end

    // Shift is done one bit wider than the accumulator so the rounding bias cannot wrap.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wide[c] = {acc_q[c][ACCW-1], acc_q[c]};
`ifdef MLACCEL_ACC_ROUND_EN
            wide[c] = wide[c] + $signed((({{ACCW{1'b0}}, 1'b1} << shAmt) >> 1));
`endif
            shifted[c] = wide[c] >>> shAmt;
            if (shifted[c] > SAT_HI)
                resByte[c] = 8'h7F;
            else if (shifted[c] < SAT_LO)
                resByte[c] = 8'h80;
            else
                resByte[c] = shifted[c][7:0];
            if ((opCode == OP_RELU) && (shifted[c] < 0))
                resByte[c] = 8'h00;
        end
    end

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            acc_d[c] = acc_q[c];
            if (fire && op_mask[c]) begin
                case (opCode)
                    OP_MACC:  acc_d[c] = acc_q[c] + laneSum[c];
                    OP_MACCZ: acc_d[c] = laneSum[c];
                    OP_MMAX:  acc_d[c] = smax(acc_q[c], laneMax[c]);
                    OP_MMAXZ: acc_d[c] = smax('0, laneMax[c]);
                    OP_MMAXN: acc_d[c] = laneMax[c];
                    OP_LDSET: acc_d[c] = ldWord[c];
                    OP_LDADD: acc_d[c] = acc_q[c] + ldWord[c];
                    OP_LDMAX: acc_d[c] = smax(acc_q[c], ldWord[c]);
                    default:  acc_d[c] = acc_q[c];
                endcase
            end
        end
    end

    // A new store may be loaded in the same cycle the previous one is consumed.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (wr_valid_q && wr_ready)
            wr_valid_d = 1'b0;
        if (fire && isStore) begin
            wr_valid_d = 1'b1;
            wr_en_d    = op_mask;
            wr_addr_d  = op_addr;
            for (int c = 0; c < NCH; c++)
                wr_data_d[8*c +: 8] = resByte[c];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++)
                acc_q[c] <= '0;
            wr_valid_q <= 1'b0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            for (int c = 0; c < NCH; c++)
                acc_q[c] <= acc_d[c];
            wr_valid_q <= wr_valid_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = wr_valid_q;

endmodule

// File: tb/tb_mlaccel_acc_bank.sv
// Bench for mlaccel_acc_bank: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic model of the accumulator bank.
module tb_mlaccel_acc_bank;

    localparam int NCH  = 2;
    localparam int SZ   = 8;
    localparam int ACCW = 32;
    localparam int AW   = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 op_valid = 1'b0;
    logic                 op_ready;
    logic [3:0]           op_code = '0;
    logic [NCH-1:0]       op_mask = '0;
    logic [NCH*SZ*16-1:0] op_prod = '0;
    logic [NCH*ACCW-1:0]  op_ldata = '0;
    logic [4:0]           op_shift = '0;
    logic [AW-1:0]        op_addr = '0;
    logic                 wr_valid;
    logic                 wr_ready = 1'b1;
    logic [NCH-1:0]       wr_en;
    logic [AW-1:0]        wr_addr;
    logic [8*NCH-1:0]     wr_data;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    longint           accM [NCH];
    bit               mWrValid;
    logic [NCH-1:0]   mWrEn;
    logic [AW-1:0]    mWrAddr;
    logic [8*NCH-1:0] mWrData;

    mlaccel_acc_bank #(.NCH(NCH), .SZ(SZ), .ACCW(ACCW), .AW(AW)) dut (
        .clock(clock), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_mask(op_mask),
        .op_prod(op_prod), .op_ldata(op_ldata), .op_shift(op_shift), .op_addr(op_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reduce an integer to its two's-complement value modulo 2^ACCW.
    function automatic longint wrapAcc(input longint x);
        logic [63:0] t;
        t = x;
        t = t << (64 - ACCW);
        return $signed(t) >>> (64 - ACCW);
    endfunction

    function automatic longint laneVal(input int c, input int i);
        logic [15:0] v;
        v = op_prod[16*(c*SZ+i) +: 16];
        return longint'($signed(v));
    endfunction

    function automatic longint nextAcc(input longint a, input int c, input int code);
        longint sum, mx, ld, v;
        logic [ACCW-1:0] raw;
        sum = 0;
        mx = laneVal(c, 0);
        for (int i = 0; i < SZ; i++) begin
            v = laneVal(c, i);
            sum += v;
            if (v > mx) mx = v;
        end
        raw = op_ldata[ACCW*c +: ACCW];
        ld = wrapAcc(longint'(raw));
        case (code)
            1:       return wrapAcc(a + sum);
            2:       return wrapAcc(sum);
            3:       return (a > mx) ? a : mx;
            4:       return (mx > 0) ? mx : 0;
            5:       return mx;
            6:       return ld;
            7:       return wrapAcc(a + ld);
            8:       return (a > ld) ? a : ld;
            default: return a;
        endcase
    endfunction

    function automatic logic [7:0] storeByte(input longint a, input int shIn, input bit relu);
        int sh;
        longint s;
        sh = (shIn >= ACCW) ? ACCW - 1 : shIn;
`ifdef MLACCEL_ACC_ROUND_EN
        if (sh > 0) a = a + (longint'(1) << (sh - 1));
`endif
        s = a >>> sh;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        if (relu && s < 0) s = 0;
        return 8'(s);
    endfunction

    // Reference model: advances on every rising edge from the inputs held there.
    always @(posedge clock) begin : model
        bit fire;
        if (reset) begin
            for (int c = 0; c < NCH; c++) accM[c] = 0;
            mWrValid = 0;
            mWrEn = '0;
            mWrAddr = '0;
            mWrData = '0;
            started = 1;
        end else begin
            fire = op_valid && (!mWrValid || wr_ready);
            if (mWrValid && wr_ready) mWrValid = 0;
            if (fire) begin
                if (op_code == 4'd9 || op_code == 4'd10) begin
                    mWrValid = 1;
                    mWrEn = op_mask;
                    mWrAddr = op_addr;
                    for (int c = 0; c < NCH; c++)
                        mWrData[8*c +: 8] = storeByte(accM[c], int'(op_shift), op_code == 4'd10);
                end else begin
                    for (int c = 0; c < NCH; c++)
                        if (op_mask[c]) accM[c] = nextAcc(accM[c], c, int'(op_code));
                end
            end
        end
    end

    always @(negedge clock) begin
        if (started) begin
            checkOutput("op_ready", 64'(op_ready), 64'(!mWrValid || wr_ready));
            checkOutput("wr_valid", 64'(wr_valid), 64'(mWrValid));
            checkOutput("busy", 64'(busy), 64'(mWrValid));
            checkOutput("wr_en", 64'(wr_en), 64'(mWrEn));
            checkOutput("wr_addr", 64'(wr_addr), 64'(mWrAddr));
            checkOutput("wr_data", 64'(wr_data), 64'(mWrData));
        end
    end

    function automatic logic [NCH*SZ*16-1:0] fillProd(input int v0, input int v1);
        logic [NCH*SZ*16-1:0] p;
        for (int i = 0; i < SZ; i++) begin
            p[16*i +: 16] = 16'(v0);
            p[16*(SZ+i) +: 16] = 16'(v1);
        end
        return p;
    endfunction

    // Present one op at posedge+1 and hold it until the edge that accepts it.
    task automatic applyStimulus(input logic [3:0] code, input logic [NCH-1:0] mask,
                                 input logic [NCH*SZ*16-1:0] prod, input logic [NCH*ACCW-1:0] ld,
                                 input logic [4:0] sh, input logic [AW-1:0] addr);
        bit rdy, done;
        op_valid = 1'b1;
        op_code = code;
        op_mask = mask;
        op_prod = prod;
        op_ldata = ld;
        op_shift = sh;
        op_addr = addr;
        done = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clock);
            rdy = op_ready;
            @(posedge clock);
            #1;
            done = rdy;
        end
        op_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
    endtask

    task automatic storeAndCheck(input string name, input logic [3:0] code, input logic [NCH-1:0] mask,
                                 input logic [4:0] sh, input logic [AW-1:0] addr,
                                 input logic [8*NCH-1:0] expData, input logic [8*NCH-1:0] dataMask);
        applyStimulus(code, mask, '0, '0, sh, addr);
        @(negedge clock);
        checkOutput({name, "_valid"}, 64'(wr_valid), 64'd1);
        checkOutput({name, "_en"}, 64'(wr_en), 64'(mask));
        checkOutput({name, "_addr"}, 64'(wr_addr), 64'(addr));
        checkOutput({name, "_data"}, 64'(wr_data & dataMask), 64'(expData));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [NCH*SZ*16-1:0] p;
        logic [7:0] roundExp;
        int cyc;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("rst_ready", 64'(op_ready), 64'd1);
        checkOutput("rst_valid", 64'(wr_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_data", 64'(wr_data), 64'd0);
        @(posedge clock);
        #1;

        applyStimulus(4'd2, 2'b11, fillProd(3, -2), '0, 5'd0, '0);
        storeAndCheck("sum", 4'd9, 2'b11, 5'd0, 16'h0040, 16'hF018, 16'hFFFF);

        applyStimulus(4'd6, 2'b01, '0, {32'd0, 32'h7FFF_FFF0}, 5'd0, '0);
        applyStimulus(4'd1, 2'b01, fillProd(4, 0), '0, 5'd0, '0);
        storeAndCheck("wrapsat", 4'd9, 2'b01, 5'd4, 16'h0041, 16'h0080, 16'h00FF);
        storeAndCheck("relu", 4'd10, 2'b01, 5'd4, 16'h0042, 16'h0000, 16'h00FF);

        p = fillProd(0, 0);
        p[15:0] = 16'(-5);    p[31:16] = 16'(-9);    p[47:32] = 16'(-1);   p[63:48] = 16'(-4);
        p[79:64] = 16'(-6);   p[95:80] = 16'(-8);    p[111:96] = 16'(-2);  p[127:112] = 16'(-7);
        applyStimulus(4'd5, 2'b01, p, '0, 5'd0, '0);
        storeAndCheck("mmaxn", 4'd9, 2'b01, 5'd0, 16'h0043, 16'h00FF, 16'h00FF);
        applyStimulus(4'd3, 2'b01, fillProd(-3, 0), '0, 5'd0, '0);
        storeAndCheck("mmax", 4'd9, 2'b01, 5'd0, 16'h0044, 16'h00FF, 16'h00FF);
        applyStimulus(4'd4, 2'b01, fillProd(-3, 0), '0, 5'd0, '0);
        storeAndCheck("mmaxz", 4'd9, 2'b01, 5'd0, 16'h0045, 16'h0000, 16'h00FF);

        applyStimulus(4'd6, 2'b10, '0, {32'd9, 32'd7}, 5'd0, '0);
        storeAndCheck("mask", 4'd9, 2'b11, 5'd0, 16'h0055, 16'h0900, 16'hFFFF);

        // Hold the write port off while a MACC waits behind the pending store.
        wr_ready = 1'b0;
        applyStimulus(4'd9, 2'b11, '0, '0, 5'd0, 16'h0066);
        op_valid = 1'b1;
        op_code = 4'd1;
        op_mask = 2'b01;
        op_prod = fillProd(1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("stall_ready", 64'(op_ready), 64'd0);
            checkOutput("stall_data", 64'(wr_data), 64'h0900);
            checkOutput("stall_addr", 64'(wr_addr), 64'h0066);
            checkOutput("stall_en", 64'(wr_en), 64'h3);
            @(posedge clock);
            #1;
        end
        wr_ready = 1'b1;
        @(negedge clock);
        checkOutput("release_ready", 64'(op_ready), 64'd1);
        @(posedge clock);
        #1;
        op_valid = 1'b0;
        @(negedge clock);
        checkOutput("release_valid", 64'(wr_valid), 64'd0);
        @(posedge clock);
        #1;
        storeAndCheck("queued", 4'd9, 2'b11, 5'd0, 16'h0067, 16'h0908, 16'hFFFF);

        applyStimulus(4'd2, 2'b01, fillProd(3, 0), '0, 5'd0, '0);
`ifdef MLACCEL_ACC_ROUND_EN
        roundExp = 8'd2;
`else
        roundExp = 8'd1;
`endif
        storeAndCheck("round", 4'd9, 2'b01, 5'd4, 16'h0070, 16'(roundExp), 16'h00FF);

        storeAndCheck("zeromask", 4'd9, 2'b00, 5'd0, 16'h0071, 16'h0000, 16'h0000);

        for (cyc = 0; cyc < 3000; cyc++) begin
            op_valid = ($urandom_range(0, 3) != 0);
            op_code = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 7)) : 4'($urandom_range(0, 15));
            op_mask = 2'($urandom_range(0, 3));
            for (int i = 0; i < NCH*SZ; i++)
                op_prod[16*i +: 16] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 40) - 20);
            for (int c = 0; c < NCH; c++)
                op_ldata[ACCW*c +: ACCW] = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                                        : 32'($urandom_range(0, 600) - 300);
            op_shift = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
            op_addr = 16'($urandom);
            wr_ready = ($urandom_range(0, 3) != 0);
            reset = (cyc == 1500 || cyc == 1501);
            @(posedge clock);
            #1;
        end
        op_valid = 1'b0;
        reset = 1'b0;
        wr_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mlaccel_acc_bank.md
Name: mlaccel_acc_bank

Overview:
- Parametrised accumulator/write-back bank for the compute pipeline. Generalises the fixed two-accumulator, 8-lane stage to NCH channels of SZ lanes each.
- Supports true signed max reduction, per-channel masking and back-pressured stores.
- Consumes product vectors from the multiplier array and load words from memory. Emits saturated 8-bit results through a valid/ready write port.

Parameters:
NCH, 2, number of accumulator channels
SZ, 8, product lanes per channel
ACCW, 32, accumulator width in bits (16 < ACCW <= 32)
AW, 16, write address width

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
op_valid  in  1  operation present
op_ready  out  1  operation accepted when op_valid && op_ready
op_code  in  4  operation, encoding below
op_mask  in  NCH  channel enable, bit c selects channel c
op_prod  in  NCH*SZ*16  signed 16-bit products, channel c lane i at [16*(c*SZ+i) +: 16]
op_ldata  in  NCH*ACCW  load word per channel
op_shift  in  5  arithmetic right shift for STORE/RELU
op_addr  in  AW  store address
wr_valid  out  1  write pending
wr_ready  in  1  write consumed when wr_valid && wr_ready
wr_en  out  NCH  byte enables
wr_addr  out  AW  write address
wr_data  out  8*NCH  byte c = result of channel c
busy  out  1  wr_valid

Behaviour:
- Op codes:
  - 0 NOP
  - 1 MACC: acc += sum(prod)
  - 2 MACCZ: acc = sum(prod)
  - 3 MMAX: acc = max(acc, prod lanes)
  - 4 MMAXZ: acc = max(0, prod lanes)
  - 5 MMAXN: acc = max(most-negative, prod lanes)
  - 6 LDSET: acc = ldata
  - 7 LDADD: acc += ldata
  - 8 LDMAX: acc = max(acc, ldata)
  - 9 STORE
  - 10 RELU
  - 11–15 reserved, treated as NOP.
- Accepted op updates every masked channel at the accepting clock edge; unmasked channels hold. All compares are signed.
- Products are sign-extended to ACCW. Sums wrap modulo 2^ACCW; no accumulate saturation.
- Ops take effect strictly in acceptance order. A STORE accepted the cycle after MACC sees the updated acc.
- STORE/RELU computation:
  - s = acc >>> op_shift (arithmetic); saturate to [-128,127].
  - RELU additionally forces negative results to 0.
  - Result is registered into the output register with wr_en = op_mask, wr_addr = op_addr; wr_valid rises the next cycle (latency 1).
  - An op_mask of all zeros still issues a write with wr_en = 0.
- op_ready = !wr_valid || wr_ready. Non-store ops are also stalled by this (single in-order stream).
- Output register holds wr_en/wr_addr/wr_data stable while wr_valid && !wr_ready.
- Back-to-back stores with wr_ready held high give one write per cycle.
- Reset:
  - All accumulators = 0, wr_valid = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0.
  - op_ready = 1 in the cycle after reset deasserts.
  - Reset mid-transfer drops the pending write.
- op_shift >= ACCW behaves as shift by ACCW-1 (result 0 or -1).

Optional Feature:
- Macro MLACCEL_ACC_ROUND_EN.
- Defined: STORE/RELU add 1 << (op_shift-1) before shifting (round-half-up); op_shift = 0 adds nothing. The rounding addition is computed at ACCW+1 bits so it never wraps.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- Reset, then MACCZ with mask=11, all ch0 products 3, all ch1 products -2 -> acc0 = 24, acc1 = -16. Then STORE shift=0, addr=0x40 -> wr_data = {0xF0, 0x18}, wr_en = 11, wr_addr = 0x40, one cycle after acceptance.
- LDSET acc0 = 0x7FFFFFF0, then MACC with lanes summing to 0x20 -> acc0 wraps to 0x80000010. STORE shift=4 -> byte0 = 0x80 (saturated -128). RELU -> byte0 = 0x00.
- MMAXN with ch0 lanes {-5,-9,-1,...,-7} -> acc0 = -1. MMAX with lanes all -3 -> acc0 stays -1. MMAXZ -> acc0 = 0.
- mask=10 on LDSET ldata={7,9} -> acc1 = 9, acc0 unchanged.
- STORE issued, wr_ready held low 3 cycles -> op_ready = 0, wr_* stable. wr_ready high -> handshake completes; the queued MACC is accepted that same cycle.
- With MLACCEL_ACC_ROUND_EN: acc0 = 24, STORE shift=4 -> byte0 = 2. Without the macro -> byte0 = 1.
